// File: rtl/tick_rate_ctrl_if.sv
// Control/status bundle for tick_rate_ctrl: rate request/acknowledge, pause/step, and tick outputs.
// rate_req and step are one-cycle pulses. rate_ack pulses once when the pending rate becomes active.
interface tick_rate_ctrl_if;
  logic [1:0] rate_sel;
  logic       rate_req;
  logic       rate_ack;
  logic       pause;
  logic       step;
  logic       tick;
  logic       clock_out;
  logic [1:0] cur_rate;
  logic       running;
  logic [1:0] dbg_state;

  modport master (
    output rate_sel, rate_req, pause, step,
    input  rate_ack, tick, clock_out, cur_rate, running, dbg_state
  );

  modport slave (
    input  rate_sel, rate_req, pause, step,
    output rate_ack, tick, clock_out, cur_rate, running, dbg_state
  );
endinterface

// File: rtl/tick_rate_ctrl.sv
// Programmable game-tick generator: four selectable periods, pause, single-step, and
// rate changes that only land on a period boundary so no period is ever truncated.
module tick_rate_ctrl #(
  parameter int unsigned      CNT_W    = 25,
  parameter logic [CNT_W-1:0] DIV0     = 25'd20000000,
  parameter logic [CNT_W-1:0] DIV1     = 25'd10000000,
  parameter logic [CNT_W-1:0] DIV2     = 25'd5000000,
  parameter logic [CNT_W-1:0] DIV3     = 25'd2500000,
  parameter logic [1:0]       INIT_SEL = 2'd2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  tick_rate_ctrl_if.slave  bus
);

  localparam logic [1:0]       ST_RUN   = 2'd0;
  localparam logic [1:0]       ST_PAUSE = 2'd1;
  localparam logic [1:0]       ST_STEP  = 2'd2;
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cur_rate_q, cur_rate_d;
  logic [1:0]       pend_sel_q, pend_sel_d;
  logic             pend_valid_q, pend_valid_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             clk_out_q, clk_out_d;

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] div_last;
  logic [CNT_W-1:0] div_half;
  logic             wrap;
  logic             apply;

  always_comb begin
    case (cur_rate_q)
      2'd0:    div = DIV0;
      2'd1:    div = DIV1;
      2'd2:    div = DIV2;
      default: div = DIV3;
    endcase
  end

  assign div_last = div - ONE;
  assign div_half = div >> 1;
  assign wrap     = (cnt_q == div_last);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_rate_d   = cur_rate_q;
    pend_sel_d   = pend_sel_q;
    pend_valid_d = pend_valid_q;
    tick_d       = 1'b0;
    ack_d        = 1'b0;
    clk_out_d    = 1'b0;
    apply        = 1'b0;

    case (state_q)
      ST_RUN: begin
        // Pause wins over a wrap on the same edge: no tick, no rate change.
        if (bus.pause) begin
          state_d = ST_PAUSE;
          cnt_d   = '0;
        end else begin
          clk_out_d = (cnt_q < div_half);
          if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            apply  = pend_valid_q;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end

      ST_STEP: begin
        clk_out_d = (cnt_q < div_half);
        if (wrap) begin
          cnt_d   = '0;
          tick_d  = 1'b1;
          apply   = pend_valid_q;
          state_d = bus.pause ? ST_PAUSE : ST_RUN;
        end else begin
          cnt_d = cnt_q + ONE;
          if (!bus.pause) state_d = ST_RUN;
        end
      end

      ST_PAUSE: begin
        cnt_d = '0;
        apply = pend_valid_q;
        if (!bus.pause)    state_d = ST_RUN;
        else if (bus.step) state_d = ST_STEP;
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    if (apply) begin
      cur_rate_d   = pend_sel_q;
      pend_valid_d = 1'b0;
      ack_d        = 1'b1;
    end
    // A request landing on the apply edge stays pending for the next boundary.
    if (bus.rate_req) begin
      pend_sel_d   = bus.rate_sel;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      cur_rate_q   <= INIT_SEL;
      pend_sel_q   <= INIT_SEL;
      pend_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      ack_q        <= 1'b0;
      clk_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_rate_q   <= cur_rate_d;
      pend_sel_q   <= pend_sel_d;
      pend_valid_q <= pend_valid_d;
      tick_q       <= tick_d;
      ack_q        <= ack_d;
      clk_out_q    <= clk_out_d;
    end
  end

  assign bus.tick      = tick_q;
  assign bus.rate_ack  = ack_q;
  assign bus.clock_out = clk_out_q;
  assign bus.cur_rate  = cur_rate_q;
  assign bus.running   = (state_q != ST_PAUSE);
  assign bus.dbg_state = state_q;

endmodule
